// File: rtl/rf_wb_stage.sv
// rf_wb_stage: write-back register stage feeding the register file write
// port, plus read-operand correction behind the registered RF read ports.
// A write request is registered for one cycle and then drives the RF write
// port. Read operands are patched with any younger or in-flight write so
// decode always sees the newest value. x0 always reads as zero.
// Optional build macro: WB_STATS_EN adds write and forward event counters.
module rf_wb_stage #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              cpu_clk,
   input  logic              cpu_rst_n,
   input  logic              wb_valid,
   input  logic [ADDR_W-1:0] wb_rd,
   input  logic [1:0]        wb_sel,
   input  logic [DATA_W-1:0] alu_c,
   input  logic [DATA_W-1:0] dram_rd,
   input  logic [DATA_W-1:0] pc4,
   input  logic [DATA_W-1:0] ext,
   input  logic [ADDR_W-1:0] rR1,
   input  logic [ADDR_W-1:0] rR2,
   input  logic [DATA_W-1:0] rf_rD1,
   input  logic [DATA_W-1:0] rf_rD2,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_wR,
   output logic [DATA_W-1:0] rf_wD,
   output logic [DATA_W-1:0] rd1_o,
   output logic [DATA_W-1:0] rd2_o
`ifdef WB_STATS_EN
   ,
   output logic [31:0]       stat_wb_cnt,
   output logic [31:0]       stat_fwd_cnt
`endif
);

   logic              valid_q;
   logic [ADDR_W-1:0] rd_q;
   logic [DATA_W-1:0] data_q;
   logic [DATA_W-1:0] wb_data;
   logic [ADDR_W-1:0] raddr_1_q, raddr_2_q;
   logic              hit_1_q, hit_2_q;
   logic [DATA_W-1:0] fwd_1_q, fwd_2_q;
   logic              young_1, young_2;
   logic              inflight_1, inflight_2;

   // Pick the write-back source for this cycle's request
   always_comb begin
      wb_data = alu_c;
      unique case (wb_sel)
         2'd0: wb_data = alu_c;
         2'd1: wb_data = dram_rd;
         2'd2: wb_data = pc4;
         2'd3: wb_data = ext;
         default: wb_data = alu_c;
      endcase
   end

   // A young hit is this cycle's request; an in-flight hit is the write the
   // RF is committing at this edge (which the RF read still misses). x0 is
   // excluded: it is never written, so the in-flight term cannot match it.
   always_comb begin
      young_1    = wb_valid && (wb_rd == rR1) && (rR1 != '0);
      young_2    = wb_valid && (wb_rd == rR2) && (rR2 != '0);
      inflight_1 = valid_q && (rd_q == rR1);
      inflight_2 = valid_q && (rd_q == rR2);
   end

   // Register the write request; writes to x0 are squashed here
   always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
      if (!cpu_rst_n) begin
         valid_q <= 1'b0;
         rd_q    <= '0;
         data_q  <= '0;
      end else begin
         valid_q <= wb_valid && (wb_rd != '0);
         rd_q    <= wb_rd;
         data_q  <= wb_data;
      end
   end

   // Re-time read addresses and capture the bypass decision, newest value first
   always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
      if (!cpu_rst_n) begin
         raddr_1_q <= '0;
         raddr_2_q <= '0;
         hit_1_q   <= 1'b0;
         hit_2_q   <= 1'b0;
         fwd_1_q   <= '0;
         fwd_2_q   <= '0;
      end else begin
         raddr_1_q <= rR1;
         raddr_2_q <= rR2;
         hit_1_q   <= young_1 || inflight_1;
         hit_2_q   <= young_2 || inflight_2;
         if (young_1)         fwd_1_q <= wb_data;
         else if (inflight_1) fwd_1_q <= data_q;
         if (young_2)         fwd_2_q <= wb_data;
         else if (inflight_2) fwd_2_q <= data_q;
      end
   end

   assign rf_we = valid_q;
   assign rf_wR = rd_q;
   assign rf_wD = data_q;

   assign rd1_o = (raddr_1_q == '0) ? '0 : (hit_1_q ? fwd_1_q : rf_rD1);
   assign rd2_o = (raddr_2_q == '0) ? '0 : (hit_2_q ? fwd_2_q : rf_rD2);

`ifdef WB_STATS_EN
   // Count issued RF writes and forwarding events; both wrap naturally
   always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
      if (!cpu_rst_n) begin
         stat_wb_cnt  <= '0;
         stat_fwd_cnt <= '0;
      end else begin
         stat_wb_cnt  <= stat_wb_cnt + {31'd0, valid_q};
         stat_fwd_cnt <= stat_fwd_cnt + {31'd0, young_1 || inflight_1}
                                      + {31'd0, young_2 || inflight_2};
      end
   end
`endif

endmodule

// File: tb/tb_rf_wb_stage.sv
// tb_rf_wb_stage: directed table of vectors for rf_wb_stage plus a
// hand-written mid-stream reset sequence.
module tb_rf_wb_stage;

   logic        cpu_clk;
   logic        cpu_rst_n;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [1:0]  wb_sel;
   logic [31:0] alu_c, dram_rd, pc4, ext;
   logic [4:0]  rR1, rR2;
   logic [31:0] rf_rD1, rf_rD2;
   logic        rf_we;
   logic [4:0]  rf_wR;
   logic [31:0] rf_wD, rd1_o, rd2_o;
`ifdef WB_STATS_EN
   logic [31:0] stat_wb_cnt, stat_fwd_cnt;
`endif

   int applied;
   int miscompares;

   typedef struct {
      logic        v;
      logic [4:0]  rd;
      logic [1:0]  sel;
      logic [31:0] alu, dram, p4, ex;
      logic [4:0]  r1, r2;
      logic [31:0] d1, d2;
      logic        e_we;
      logic [4:0]  e_wr;
      logic [31:0] e_wd, e_rd1, e_rd2;
      int          nfwd;
   } vec_t;

   vec_t vecs[13];

   rf_wb_stage #(.DATA_W(32), .ADDR_W(5)) dut (
      .cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_sel(wb_sel),
      .alu_c(alu_c), .dram_rd(dram_rd), .pc4(pc4), .ext(ext),
      .rR1(rR1), .rR2(rR2), .rf_rD1(rf_rD1), .rf_rD2(rf_rD2),
      .rf_we(rf_we), .rf_wR(rf_wR), .rf_wD(rf_wD),
      .rd1_o(rd1_o), .rd2_o(rd2_o)
`ifdef WB_STATS_EN
      , .stat_wb_cnt(stat_wb_cnt), .stat_fwd_cnt(stat_fwd_cnt)
`endif
   );

   // Free-running clock, 10 time units per cycle
   initial cpu_clk = 1'b0;
   always #5 cpu_clk = ~cpu_clk;

   task automatic checkOutput(input string name, input int idx,
                              input logic [31:0] act, input logic [31:0] exp);
      applied++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s (step %0d): got 0x%08h, expected 0x%08h",
                  name, idx, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t t);
      wb_valid = t.v;   wb_rd = t.rd;   wb_sel = t.sel;
      alu_c = t.alu;    dram_rd = t.dram; pc4 = t.p4; ext = t.ex;
      rR1 = t.r1;       rR2 = t.r2;
      rf_rD1 = t.d1;    rf_rD2 = t.d2;
   endtask

   initial begin
      vec_t idle;
      logic [31:0] exp_wb, exp_fwd;
      logic        prev_we;
      applied = 0;
      miscompares = 0;

      //          v  rd   sel alu        dram   pc4    ext    r1 r2 d1          d2          we wr e_wd       rd1        rd2    nfwd
      vecs[0]  = '{1, 5'd5, 2'd0, 32'h11,   32'h22, 32'h33, 32'h44, 0, 0, 0,          0,          1, 5, 32'h11,   0,         0,     0};
      vecs[1]  = '{1, 5'd5, 2'd1, 32'h11,   32'h22, 32'h33, 32'h44, 0, 0, 0,          0,          1, 5, 32'h22,   0,         0,     0};
      vecs[2]  = '{1, 5'd5, 2'd2, 32'h11,   32'h22, 32'h33, 32'h44, 0, 0, 0,          0,          1, 5, 32'h33,   0,         0,     0};
      vecs[3]  = '{1, 5'd5, 2'd3, 32'h11,   32'h22, 32'h33, 32'h44, 0, 0, 0,          0,          1, 5, 32'h44,   0,         0,     0};
      vecs[4]  = '{0, 5'd0, 2'd0, 0,        0,      0,      0,      3, 0, 32'h1234,   32'hBEEF,   0, 0, 0,        32'h1234,  0,     0};
      vecs[5]  = '{1, 5'd0, 2'd0, 32'hFFFF, 0,      0,      0,      0, 0, 32'hDEAD,   0,          0, 0, 32'hFFFF, 0,         0,     0};
      vecs[6]  = '{1, 5'd7, 2'd0, 32'hA5,   0,      0,      0,      7, 0, 0,          0,          1, 7, 32'hA5,   32'hA5,    0,     1};
      vecs[7]  = '{1, 5'd9, 2'd0, 32'h1,    0,      0,      0,      0, 0, 0,          0,          1, 9, 32'h1,    0,         0,     0};
      vecs[8]  = '{0, 5'd0, 2'd0, 0,        0,      0,      0,      0, 9, 0,          0,          0, 0, 0,        0,         32'h1, 1};
      vecs[9]  = '{1, 5'd9, 2'd0, 32'h1,    0,      0,      0,      0, 0, 0,          0,          1, 9, 32'h1,    0,         0,     0};
      vecs[10] = '{1, 5'd9, 2'd1, 0,        32'h2,  0,      0,      0, 9, 0,          0,          1, 9, 32'h2,    0,         32'h2, 1};
      vecs[11] = '{0, 5'd0, 2'd0, 0,        0,      0,      0,      9, 9, 0,          0,          0, 0, 0,        32'h2,     32'h2, 2};
      vecs[12] = '{0, 5'd0, 2'd0, 0,        0,      0,      0,      9, 9, 32'h77,     32'h88,     0, 0, 0,        32'h77,    32'h88,0};
      idle     = '{0, 5'd0, 2'd0, 0,        0,      0,      0,      0, 0, 32'hDEAD,   32'hDEAD,   0, 0, 0,        0,         0,     0};

      // Reset state
      applyStimulus(idle);
      cpu_rst_n = 1'b0;
      repeat (2) @(posedge cpu_clk);
      #1;
      checkOutput("reset_we",  -1, {31'd0, rf_we}, 0);
      checkOutput("reset_wR",  -1, {27'd0, rf_wR}, 0);
      checkOutput("reset_wD",  -1, rf_wD, 0);
      checkOutput("reset_rd1", -1, rd1_o, 0);
      checkOutput("reset_rd2", -1, rd2_o, 0);
      @(negedge cpu_clk);
      cpu_rst_n = 1'b1;

      // Table-driven vectors: drive on the falling edge, check after the rise
      exp_wb = 0;
      exp_fwd = 0;
      prev_we = 1'b0;
      for (int i = 0; i < 13; i++) begin
         @(negedge cpu_clk);
         applyStimulus(vecs[i]);
         @(posedge cpu_clk);
         #1;
         exp_wb  = exp_wb + {31'd0, prev_we};
         exp_fwd = exp_fwd + vecs[i].nfwd;
         prev_we = vecs[i].e_we;
         checkOutput("rf_we", i, {31'd0, rf_we}, {31'd0, vecs[i].e_we});
         checkOutput("rf_wR", i, {27'd0, rf_wR}, {27'd0, vecs[i].e_wr});
         checkOutput("rf_wD", i, rf_wD, vecs[i].e_wd);
         checkOutput("rd1_o", i, rd1_o, vecs[i].e_rd1);
         checkOutput("rd2_o", i, rd2_o, vecs[i].e_rd2);
`ifdef WB_STATS_EN
         checkOutput("stat_wb_cnt",  i, stat_wb_cnt,  exp_wb);
         checkOutput("stat_fwd_cnt", i, stat_fwd_cnt, exp_fwd);
`endif
      end

      // Mid-stream reset: a request is accepted, another is pending when reset hits
      @(negedge cpu_clk);
      wb_valid = 1'b1; wb_rd = 5'd12; wb_sel = 2'd0; alu_c = 32'hCC;
      rR1 = 5'd12; rR2 = 5'd12; rf_rD1 = 32'h5; rf_rD2 = 32'h6;
      @(posedge cpu_clk);
      #1;
      checkOutput("pre_rst_we", 100, {31'd0, rf_we}, 1);
      checkOutput("pre_rst_wR", 100, {27'd0, rf_wR}, 12);
      checkOutput("pre_rst_rd1", 100, rd1_o, 32'hCC);
      @(negedge cpu_clk);
      wb_rd = 5'd13; alu_c = 32'hDD; rR1 = 5'd13;
      #2;
      cpu_rst_n = 1'b0;
      #1;
      checkOutput("in_rst_we",  101, {31'd0, rf_we}, 0);
      checkOutput("in_rst_rd1", 101, rd1_o, 0);
      checkOutput("in_rst_rd2", 101, rd2_o, 0);
      @(posedge cpu_clk);
      #1;
      checkOutput("held_rst_we", 102, {31'd0, rf_we}, 0);
      checkOutput("held_rst_wD", 102, rf_wD, 0);
      @(negedge cpu_clk);
      applyStimulus(idle);
      cpu_rst_n = 1'b1;
      @(posedge cpu_clk);
      #1;
      checkOutput("post_rst_we",  103, {31'd0, rf_we}, 0);
      checkOutput("post_rst_wR",  103, {27'd0, rf_wR}, 0);
      checkOutput("post_rst_rd1", 103, rd1_o, 0);
`ifdef WB_STATS_EN
      checkOutput("post_rst_wb_cnt",  103, stat_wb_cnt,  0);
      checkOutput("post_rst_fwd_cnt", 103, stat_fwd_cnt, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end

endmodule
